serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width in bits, legal range 2..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 SHALL have port minuend  input  WIDTH  operand A, captured on the accepted start.
REQ-006 SHALL have port subtrahend  input  WIDTH  operand B, captured on the accepted start.
REQ-007 SHALL have port borrow_in  input  1  initial borrow, captured on the accepted start.
REQ-008 SHALL have port busy  output  1  high while bits are being processed.
REQ-009 SHALL have port done  output  1  one-cycle pulse when the result is valid.
REQ-010 SHALL have port diff  output  WIDTH  result A - B - borrow_in, modulo 2^WIDTH.
REQ-011 SHALL have port borrow_out  output  1  final borrow out of the MSB stage.

Function
REQ-012 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-013 SHALL, in IDLE with start=1, load the operand shift registers and the borrow register from the inputs, clear the bit counter, and enter SHIFT.
REQ-014 SHALL, in each SHIFT cycle, process one bit LSB-first with a full-subtractor cell: d = a^b^bin; bout = (~a&b)|(~a&bin)|(b&bin).
REQ-015 SHALL, in each SHIFT cycle, shift d into the result register MSB-first and register bout as the next bin.
REQ-016 SHALL stay in SHIFT for exactly WIDTH cycles, then enter DONE.
REQ-017 SHALL hold DONE for exactly one cycle, then return to IDLE unconditionally.
REQ-018 SHALL meet this latency: start sampled at edge N; busy=1 from cycles N+1 through N+WIDTH; done=1 in cycle N+WIDTH+1 only.
REQ-019 SHALL drive valid diff and borrow_out from the DONE cycle onward, holding them until the next accepted start.
REQ-020 SHALL ignore start while in SHIFT or DONE, with no effect on the operation in flight.
REQ-021 SHALL leave diff and borrow_out undefined during SHIFT; downstream logic samples them only on done.
REQ-022 SHALL, when start is held high continuously, accept it again in the first IDLE cycle after DONE, giving a throughput of one result per WIDTH+2 cycles.
REQ-023 SHALL count bits with a counter of width ceil(log2(WIDTH))+1 so the counter cannot wrap before the terminal count.

Reset
REQ-024 SHALL, on rst=1 at a rising edge, force state=IDLE, busy=0, done=0, diff=0, borrow_out=0 and clear the counter and the borrow register.
REQ-025 SHALL give rst priority over start and over any state, including reset asserted mid-SHIFT, which abandons the operation with no done pulse.
REQ-026 SHALL accept start in the first cycle after rst deasserts.

Configuration
REQ-027 SHALL compile in, when macro SERIAL_SUBTRACTOR_OVERFLOW_EN is defined, an output overflow (1 bit, reset 0), valid and held under the same rules as diff.
REQ-028 SHALL compute overflow as the signed two's-complement overflow (bin into the MSB stage) XOR (bout out of the MSB stage), captured during the final SHIFT cycle.
REQ-029 SHALL, when SERIAL_SUBTRACTOR_OVERFLOW_EN is undefined, omit the overflow port and its logic, with all other behaviour identical.

Verification
REQ-030 SHALL pass: WIDTH=8, A=0x05, B=0x03, bin=0 -> done at start+9 cycles, diff=0x02, borrow_out=0, busy high for exactly 8 cycles.
REQ-031 SHALL pass: A=0x00, B=0x01, bin=0 -> diff=0xFF, borrow_out=1; A=0x10, B=0x0F, bin=1 -> diff=0x00, borrow_out=0.
REQ-032 SHALL pass, with overflow enabled: A=0x80, B=0x01 -> diff=0x7F, overflow=1, borrow_out=0; A=0x7F, B=0x01 -> diff=0x7E, overflow=0.
REQ-033 SHALL pass: start pulsed with new operands during SHIFT -> ignored, first result unchanged, exactly one done pulse.
REQ-034 SHALL pass: rst asserted in the 4th SHIFT cycle -> next cycle busy=0, done=0, diff=0; no done pulse; a new start then completes correctly.
REQ-035 SHALL pass: start held high for 3 operations -> done pulses spaced exactly WIDTH+2 cycles apart, each result correct.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - borrow_in, one bit per clock, LSB first, through a single full-subtractor cell.
// Define SERIAL_SUBTRACTOR_OVERFLOW_EN to add the signed-overflow output.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] minuend,
   input  logic [WIDTH-1:0] subtrahend,
   input  logic             borrow_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
   output logic             overflow,
`endif
   output logic [1:0]       fsm_state
);

   // One extra counter bit so the terminal count can never alias to zero.
   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic             bin_r;
   logic [CNT_W-1:0] cnt;
   logic             d_bit;
   logic             bout_bit;
   logic             last_bit;
   logic             load;

   always_comb begin
      d_bit    = a_sr[0] ^ b_sr[0] ^ bin_r;
      bout_bit = (~a_sr[0] & b_sr[0]) | (~a_sr[0] & bin_r) | (b_sr[0] & bin_r);
      last_bit = (cnt == LAST_BIT);
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (last_bit) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr       <= '0;
         b_sr       <= '0;
         res_sr     <= '0;
         bin_r      <= 1'b0;
         cnt        <= '0;
         borrow_out <= 1'b0;
      end else if (load) begin
         a_sr  <= minuend;
         b_sr  <= subtrahend;
         bin_r <= borrow_in;
         cnt   <= '0;
      end else if (state == SHIFT) begin
         // Result enters at the MSB so bit 0 lands at the LSB after WIDTH shifts.
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         res_sr <= {d_bit, res_sr[WIDTH-1:1]};
         bin_r  <= bout_bit;
         cnt    <= cnt + 1'b1;
         if (last_bit) borrow_out <= bout_bit;
      end
   end

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
   // Signed overflow: borrow into the MSB cell differs from borrow out of it.
   always_ff @(posedge clk) begin
      if (rst)                             overflow <= 1'b0;
      else if ((state == SHIFT) && last_bit) overflow <= bin_r ^ bout_bit;
   end
`endif

   assign diff      = res_sr;
   assign busy      = (state == SHIFT);
   assign done      = (state == DONE);
   assign fsm_state = state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, corner sequences and random ops vs. an arithmetic model.
// Handshake: start is sampled only in IDLE; results are read while done is high and then stay held.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] minuend;
   logic [W-1:0] subtrahend;
   logic         borrow_in;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow_out;
   logic [1:0]   fsm_state;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
   logic         overflow;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .minuend    (minuend),
      .subtrahend (subtrahend),
      .borrow_in  (borrow_in),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out),
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      .overflow   (overflow),
`endif
      .fsm_state  (fsm_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bin;
      logic [W-1:0] exp_diff;
      logic         exp_bout;
      logic         exp_ovf;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                                 output logic [W-1:0] d, output logic bo, output logic ov);
      int ur;
      int sr;
      ur = int'(a) - int'(b) - int'(bin);
      sr = int'($signed(a)) - int'($signed(b)) - int'(bin);
      d  = ur[W-1:0];
      bo = (ur < 0);
      ov = (sr > (2 ** (W - 1)) - 1) || (sr < -(2 ** (W - 1)));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Caller is 1 time unit after a rising edge; start is pulsed for one cycle.
   task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic bin, input logic [W-1:0] ed, input logic ebo, input logic eov);
      int cyc;
      int busy_n;
      bit seen;
      logic [W-1:0] held;
      start      = 1'b1;
      minuend    = a;
      subtrahend = b;
      borrow_in  = bin;
      tick();
      start      = 1'b0;
      minuend    = W'($urandom);
      subtrahend = W'($urandom);
      borrow_in  = 1'($urandom);
      cyc = 1;
      busy_n = 0;
      seen = 1'b0;
      while (cyc <= W + 4) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) busy_n++;
         tick();
         cyc++;
      end
      check({name, " done_seen"}, 32'(seen), 32'd1);
      check({name, " latency"}, 32'(cyc), 32'(W + 1));
      check({name, " busy_cycles"}, 32'(busy_n), 32'(W));
      check({name, " diff"}, 32'(diff), 32'(ed));
      check({name, " borrow_out"}, 32'(borrow_out), 32'(ebo));
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      check({name, " overflow"}, 32'(overflow), 32'(eov));
`else
      if (eov === 1'bx) $display("note: undefined overflow expectation in %s", name);
`endif
      held = diff;
      tick();
      check({name, " done_one_cycle"}, 32'(done), 32'd0);
      check({name, " diff_held"}, 32'(diff), 32'(held));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [W-1:0] ed;
      logic         ebo;
      logic         eov;
      logic [W-1:0] a3[3];
      logic [W-1:0] b3[3];
      logic         c3[3];
      int           cyc;
      int           k;
      int           last_done;
      int           dones;
      logic [W-1:0] got_d;
      logic         got_b;

      vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
      vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
      vecs[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
      vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
      vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0};
      vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[7] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};

      // Clock/reset
      rst = 1'b1;
      start = 1'b1;
      minuend = 8'hAA;
      subtrahend = 8'h11;
      borrow_in = 1'b1;
      repeat (3) tick();
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset diff", 32'(diff), 32'd0);
      check("reset borrow_out", 32'(borrow_out), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
      check("reset overflow", 32'(overflow), 32'd0);
`endif
      rst = 1'b0;

      // Vector table; the first op starts in the first cycle after reset release.
      for (int i = 0; i < 8; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
                vecs[i].exp_diff, vecs[i].exp_bout, vecs[i].exp_ovf);
      end

      // Start pulsed with new operands while SHIFT is in flight.
      start = 1'b1; minuend = 8'h5A; subtrahend = 8'h33; borrow_in = 1'b0;
      tick();
      start = 1'b0;
      tick(); tick();
      start = 1'b1; minuend = 8'hFF; subtrahend = 8'h00; borrow_in = 1'b1;
      tick();
      start = 1'b0;
      dones = 0; got_d = '0; got_b = 1'b0;
      for (int c = 4; c <= W + 6; c++) begin
         if (done) begin
            dones++;
            got_d = diff;
            got_b = borrow_out;
         end
         tick();
      end
      check("ignore_start dones", 32'(dones), 32'd1);
      check("ignore_start diff", 32'(got_d), 32'h27);
      check("ignore_start borrow_out", 32'(got_b), 32'd0);
      check("ignore_start idle_after", 32'(busy), 32'd0);

      // Reset during the 4th SHIFT cycle abandons the operation.
      start = 1'b1; minuend = 8'hC3; subtrahend = 8'h21; borrow_in = 1'b0;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      check("midreset in_shift", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midreset busy", 32'(busy), 32'd0);
      check("midreset done", 32'(done), 32'd0);
      check("midreset diff", 32'(diff), 32'd0);
      dones = 0;
      for (int c = 0; c < 2 * W; c++) begin
         if (done || busy) dones++;
         tick();
      end
      check("midreset no_activity", 32'(dones), 32'd0);
      run_op("after_reset", 8'hC3, 8'h21, 1'b0, 8'hA2, 1'b0, 1'b0);

      // Start held high across three back-to-back operations.
      for (int i = 0; i < 3; i++) begin
         a3[i] = W'($urandom);
         b3[i] = W'($urandom);
         c3[i] = 1'($urandom);
      end
      start = 1'b1; minuend = a3[0]; subtrahend = b3[0]; borrow_in = c3[0];
      tick();
      minuend = W'($urandom); subtrahend = W'($urandom); borrow_in = 1'($urandom);
      cyc = 1; k = 0; last_done = 0;
      while (k < 3 && cyc < 3 * (W + 2) + 10) begin
         if (done) begin
            model(a3[k], b3[k], c3[k], ed, ebo, eov);
            check($sformatf("held%0d diff", k), 32'(diff), 32'(ed));
            check($sformatf("held%0d borrow_out", k), 32'(borrow_out), 32'(ebo));
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            check($sformatf("held%0d overflow", k), 32'(overflow), 32'(eov));
`endif
            if (k == 0) check("held0 latency", 32'(cyc), 32'(W + 1));
            else check($sformatf("held%0d spacing", k), 32'(cyc - last_done), 32'(W + 2));
            last_done = cyc;
            k++;
            if (k < 3) begin
               minuend = a3[k]; subtrahend = b3[k]; borrow_in = c3[k];
            end else begin
               start = 1'b0;
            end
         end
         tick();
         cyc++;
      end
      start = 1'b0;
      check("held results", 32'(k), 32'd3);
      tick(); tick();

      // Random operations against the model.
      for (int i = 0; i < 24; i++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         logic         rc;
         ra = W'($urandom_range(0, 255));
         rb = W'($urandom_range(0, 255));
         rc = 1'($urandom_range(0, 1));
         model(ra, rb, rc, ed, ebo, eov);
         run_op($sformatf("rand%0d", i), ra, rb, rc, ed, ebo, eov);
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
